// File: rtl/glyph_rom_scan.sv
// Operator-glyph bitmap ROM with a registered lookup port and a row-scan streaming engine.
// Optional build macro GLYPH_INVERT_EN adds an invert input that complements output bitmaps.
module glyph_rom_scan #(
   parameter int GLYPH_W    = 16,
   parameter int GLYPH_H    = 16,
   parameter int NUM_GLYPHS = 4,
   parameter int GSEL_W     = 2,
   parameter int ROW_W      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef GLYPH_INVERT_EN
   input  logic                invert,
`endif
   input  logic [GSEL_W-1:0]   lk_glyph,
   input  logic [ROW_W-1:0]    lk_row,
   output logic [0:GLYPH_W-1]  lk_data,
   input  logic                scan_start,
   input  logic [GSEL_W-1:0]   scan_glyph,
   output logic                scan_busy,
   output logic                row_valid,
   input  logic                row_ready,
   output logic [0:GLYPH_W-1]  row_data,
   output logic [ROW_W-1:0]    row_idx,
   output logic                row_last
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(GLYPH_H - 1);

   // Glyph bitmap for (glyph, row); out-of-range coordinates yield a blank row before inversion.
   function automatic logic [0:GLYPH_W-1] f_rom_row(
      input logic [GSEL_W-1:0] g,
      input logic [ROW_W-1:0]  r,
      input logic              inv
   );
      logic [0:GLYPH_W-1] row;
      logic               minus_row;
      logic               equals_row;
      int                 gi;
      int                 ri;
      gi = int'(g);
      ri = int'(r);
      row = '0;
      minus_row  = (ri >= GLYPH_H/2 - 1) && (ri <= GLYPH_H/2 + 1);
      equals_row = ((ri >= GLYPH_H/4) && (ri <= GLYPH_H/4 + 2)) ||
                   ((ri >= GLYPH_H - GLYPH_H/4 - 3) && (ri <= GLYPH_H - GLYPH_H/4 - 1));
      if ((gi < NUM_GLYPHS) && (ri < GLYPH_H)) begin
         case (gi)
            1: begin
               if (minus_row) row = '1;
               else           row = '0;
            end
            2: begin
               if (minus_row) begin
                  row = '1;
               end else begin
                  row = '0;
                  row[GLYPH_W/2 - 1] = 1'b1;
                  row[GLYPH_W/2]     = 1'b1;
               end
            end
            3: begin
               if (equals_row) row = '1;
               else            row = '0;
            end
            default: row = '0;
         endcase
      end else begin
         row = '0;
      end
      return inv ? ~row : row;
   endfunction

   logic               w_inv_in;
`ifdef GLYPH_INVERT_EN
   assign w_inv_in = invert;
`else
   assign w_inv_in = 1'b0;
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ROW_W-1:0]   r_row;
   logic [ROW_W-1:0]   w_row_nxt;
   logic [GSEL_W-1:0]  r_glyph;
   logic [GSEL_W-1:0]  w_glyph_nxt;
   logic               r_inv;
   logic               w_inv_nxt;
   logic               r_valid;
   logic               r_last;
   logic [0:GLYPH_W-1] r_data;
   logic [0:GLYPH_W-1] r_lk;

   // Lookup port: one-cycle registered read, independent of the scan engine.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lk <= '0;
      end else begin
         r_lk <= f_rom_row(lk_glyph, lk_row, w_inv_in);
      end
   end

   // Scan next-state: start only from IDLE, advance one row per accepted beat, stop after the last row.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_glyph_nxt = r_glyph;
      w_inv_nxt   = r_inv;
      case (r_state)
         ST_IDLE: begin
            if (scan_start) begin
               w_state_nxt = ST_STREAM;
               w_row_nxt   = '0;
               w_glyph_nxt = scan_glyph;
               w_inv_nxt   = w_inv_in;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (row_ready) begin
               if (r_row == LAST_ROW) begin
                  w_state_nxt = ST_IDLE;
                  w_row_nxt   = '0;
               end else begin
                  w_row_nxt   = r_row + ROW_W'(1);
               end
            end else begin
               w_state_nxt = ST_STREAM;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_row_nxt   = '0;
         end
      endcase
   end

   // Scan state and registered stream outputs, all derived from the next-state values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_glyph <= '0;
         r_inv   <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_glyph <= w_glyph_nxt;
         r_inv   <= w_inv_nxt;
         r_valid <= (w_state_nxt == ST_STREAM);
         r_last  <= (w_state_nxt == ST_STREAM) && (w_row_nxt == LAST_ROW);
         r_data  <= (w_state_nxt == ST_STREAM) ? f_rom_row(w_glyph_nxt, w_row_nxt, w_inv_nxt)
                                               : '0;
      end
   end

   assign lk_data   = r_lk;
   assign scan_busy = r_valid;
   assign row_valid = r_valid;
   assign row_data  = r_data;
   assign row_idx   = r_row;
   assign row_last  = r_last;

endmodule

// File: tb/tb_glyph_rom_scan.sv
// Directed, table-driven bench for glyph_rom_scan: lookup vectors plus scan-engine sequences.
module tb_glyph_rom_scan;

`ifdef GLYPH_INVERT_EN
   localparam int NG = 3;
`else
   localparam int NG = 4;
`endif

   logic        clk;
   logic        rst_n;
   logic        invert;
   logic [1:0]  lk_glyph;
   logic [3:0]  lk_row;
   logic [0:15] lk_data;
   logic        scan_start;
   logic [1:0]  scan_glyph;
   logic        scan_busy;
   logic        row_valid;
   logic        row_ready;
   logic [0:15] row_data;
   logic [3:0]  row_idx;
   logic        row_last;

   int n_tests;
   int n_fail;

   typedef struct {
      logic [1:0]  glyph;
      logic [3:0]  row;
      logic [15:0] exp;
   } lk_vec_t;

   lk_vec_t     lk_vecs[15];
   logic [15:0] exp_g1[16];
   logic [15:0] exp_g3[16];

   glyph_rom_scan #(
      .GLYPH_W(16), .GLYPH_H(16), .NUM_GLYPHS(NG), .GSEL_W(2), .ROW_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef GLYPH_INVERT_EN
      .invert(invert),
`endif
      .lk_glyph(lk_glyph),
      .lk_row(lk_row),
      .lk_data(lk_data),
      .scan_start(scan_start),
      .scan_glyph(scan_glyph),
      .scan_busy(scan_busy),
      .row_valid(row_valid),
      .row_ready(row_ready),
      .row_data(row_data),
      .row_idx(row_idx),
      .row_last(row_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_row(input logic [1:0] g, input int r, input logic inv);
      logic [15:0] v;
      case (g)
         2'd1:    v = exp_g1[r];
         2'd3:    v = exp_g3[r];
         default: v = 16'h0000;
      endcase
      return inv ? ~v : v;
   endfunction

   // Must be entered at a negedge; asserts start there, then consumes the stream.
   // toggle: row_ready alternates 1/0. poke: re-pulse scan_start mid-stream and on the final beat.
   task automatic run_scan(input logic [1:0] g, input logic inv, input bit toggle, input bit poke);
      int n;
      n = 0;
      scan_start = 1'b1;
      scan_glyph = g;
      invert     = inv;
      @(negedge clk);
      scan_start = 1'b0;
      scan_glyph = 2'd2;
      invert     = 1'b0;
      chk("scan_first_beat", {row_valid, scan_busy, row_idx}, {1'b1, 1'b1, 4'd0});
      for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
         row_ready  = toggle ? (cyc % 2 == 0) : 1'b1;
         scan_start = poke && (n == 5 || n == 15);
         scan_glyph = 2'd3 - g;
         if (row_valid) begin
            chk($sformatf("beat%0d", n), {row_idx, row_last, row_data},
                {n[3:0], (n == 15), exp_row(g, n, inv)});
            if (row_ready) n++;
         end else begin
            chk("valid_dropped", {28'd0, n[3:0]}, 32'd16);
            n = 16;
         end
         @(negedge clk);
      end
      scan_start = 1'b0;
      row_ready  = 1'b0;
      chk("scan_done", {row_valid, scan_busy, row_last, n[4:0]}, {1'b0, 1'b0, 1'b0, 5'd16});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n = 1'b0; invert = 1'b0; lk_glyph = 2'd0; lk_row = 4'd0;
      scan_start = 1'b0; scan_glyph = 2'd0; row_ready = 1'b0;

      for (int r = 0; r < 16; r++) begin
         exp_g1[r] = (r >= 7 && r <= 9) ? 16'hFFFF : 16'h0000;
         exp_g3[r] = ((r >= 4 && r <= 6) || (r >= 9 && r <= 11)) ? 16'hFFFF : 16'h0000;
      end
      lk_vecs[0]  = '{2'd1, 4'd8,  16'hFFFF};
      lk_vecs[1]  = '{2'd1, 4'd6,  16'h0000};
      lk_vecs[2]  = '{2'd2, 4'd0,  16'h0180};
      lk_vecs[3]  = '{2'd1, 4'd7,  16'hFFFF};
      lk_vecs[4]  = '{2'd1, 4'd9,  16'hFFFF};
      lk_vecs[5]  = '{2'd1, 4'd10, 16'h0000};
      lk_vecs[6]  = '{2'd2, 4'd8,  16'hFFFF};
      lk_vecs[7]  = '{2'd2, 4'd15, 16'h0180};
      lk_vecs[8]  = '{2'd2, 4'd6,  16'h0180};
      lk_vecs[9]  = '{2'd0, 4'd8,  16'h0000};
      lk_vecs[10] = '{2'd1, 4'd0,  16'h0000};
      lk_vecs[11] = '{2'd2, 4'd10, 16'h0180};
      lk_vecs[12] = '{2'd2, 4'd9,  16'hFFFF};
      lk_vecs[13] = '{2'd0, 4'd15, 16'h0000};
      lk_vecs[14] = '{2'd1, 4'd15, 16'h0000};

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", {lk_data, row_valid, scan_busy, row_last}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_outputs", {row_valid, scan_busy, row_idx, row_data}, 32'd0);

      // Lookup vectors
      for (int i = 0; i < 15; i++) begin
         lk_glyph = lk_vecs[i].glyph;
         lk_row   = lk_vecs[i].row;
         @(negedge clk);
         chk($sformatf("lk_vec%0d", i), {16'd0, lk_data}, {16'd0, lk_vecs[i].exp});
      end
`ifndef GLYPH_INVERT_EN
      lk_glyph = 2'd3; lk_row = 4'd5;
      @(negedge clk);
      chk("lk_equals_row5", {16'd0, lk_data}, 32'h0000FFFF);
      lk_row = 4'd8;
      @(negedge clk);
      chk("lk_equals_row8", {16'd0, lk_data}, 32'h00000000);
`endif

      // Full-throughput scan, then a stalled scan
`ifndef GLYPH_INVERT_EN
      run_scan(2'd3, 1'b0, 1'b0, 1'b0);
`endif
      run_scan(2'd1, 1'b0, 1'b1, 1'b0);
      // Starts while busy ignored; restart right after busy falls is accepted
      run_scan(2'd1, 1'b0, 1'b0, 1'b1);
      run_scan(2'd2 - 2'd2, 1'b0, 1'b0, 1'b0);

`ifdef GLYPH_INVERT_EN
      run_scan(2'd0, 1'b1, 1'b0, 1'b0);
      run_scan(2'd1, 1'b1, 1'b1, 1'b0);
      invert = 1'b1; lk_glyph = 2'd3; lk_row = 4'd5;
      @(negedge clk);
      chk("lk_inv_out_of_range", {16'd0, lk_data}, 32'h0000FFFF);
      invert = 1'b0; lk_glyph = 2'd1; lk_row = 4'd8;
      @(negedge clk);
      chk("lk_inv_per_cycle", {16'd0, lk_data}, 32'h0000FFFF);
`endif

      // Asynchronous reset mid-stream
      scan_start = 1'b1; scan_glyph = 2'd1; row_ready = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_reset_streaming", {row_valid, row_idx, row_data}, {1'b1, 4'd7, 16'hFFFF});
      lk_glyph = 2'd1; lk_row = 4'd8;
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_outputs",
          {lk_data, row_valid, scan_busy, row_last, row_idx, row_data != 16'h0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("no_resume_after_reset", {row_valid, scan_busy, row_idx}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/glyph_rom_scan.md
Name: glyph_rom_scan

Overview:
Parametrised operator-glyph bitmap ROM holding NUM_GLYPHS monochrome glyphs of GLYPH_W x GLYPH_H pixels. It is the next generation of the single-glyph operator ROMs in the number-recognition/operator display path. It provides two read paths. The first is a registered random-access lookup port used by the recogniser comparator. The second is a row-scan engine that streams a whole glyph to the VGA/display writer under a valid/ready handshake.

Parameters:
GLYPH_W, 16, pixels per row; row word is [0:GLYPH_W-1], index 0 = leftmost pixel
GLYPH_H, 16, rows per glyph (>= 12)
NUM_GLYPHS, 4, glyphs stored; glyph codes 0..NUM_GLYPHS-1
GSEL_W, 2, glyph-select width (>= clog2(NUM_GLYPHS))
ROW_W, 4, row-index width (>= clog2(GLYPH_H))

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
lk_glyph  in  GSEL_W  lookup glyph code
lk_row  in  ROW_W  lookup row index
lk_data  out  GLYPH_W  lookup row bitmap, registered
scan_start  in  1  single-cycle request to stream a glyph
scan_glyph  in  GSEL_W  glyph code, sampled with scan_start
scan_busy  out  1  scan engine active
row_valid  out  1  row_data/row_idx/row_last valid
row_ready  in  1  consumer accepts row
row_data  out  GLYPH_W  streamed row bitmap
row_idx  out  ROW_W  row number of row_data
row_last  out  1  marks row GLYPH_H-1

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: all outputs 0; scan FSM in IDLE.
- Glyph contents (ROM initialised at elaboration, content is a function of the parameters):
  - 0 blank: all rows 0.
  - 1 minus: rows H/2-1..H/2+1 all ones (7,8,9 at default).
  - 2 plus: minus rows, plus columns W/2-1 and W/2 set in every row.
  - 3 equals: rows H/4..H/4+2 and H-H/4-3..H-H/4-1 all ones (4-6, 9-11).
  - Codes >=4 and <NUM_GLYPHS: blank.
- Out-of-range accesses: glyph code >= NUM_GLYPHS or row >= GLYPH_H reads all zeros.
- Lookup port: lk_data <= rom[lk_glyph][lk_row] every cycle. Latency 1, no enable, independent of the scan engine.
- Scan FSM, states IDLE and STREAM:
  - IDLE: scan_start=1 latches scan_glyph, row counter=0, moves to STREAM. The next cycle has row_valid=1, row_idx=0, scan_busy=1.
  - STREAM: row_valid stays high. row_data/row_idx/row_last are held stable while row_valid && !row_ready.
  - A beat transfers on row_valid && row_ready. On transfer with row_idx < H-1, the next row is presented the following cycle, giving 1 row/clk at full throughput.
  - Transfer with row_last=1 returns to IDLE. row_valid, scan_busy and row_last are 0 the next cycle.
- scan_start while scan_busy=1 is ignored, including the final-transfer cycle. The earliest new start is accepted in the cycle after scan_busy falls.
- Glyph latch: scan_glyph is latched only on an accepted start; later changes to it do not affect the stream.
- Row counter: wraps never. It terminates at GLYPH_H-1.
- Reset mid-stream: the stream aborts immediately, all outputs return to 0 and the FSM returns to IDLE. No partial resume.

Optional Feature:
Macro GLYPH_INVERT_EN.
- Defined: adds input port invert (1 bit). When invert=1, lk_data and row_data present the bitwise complement of the ROM row, and out-of-range reads return all ones. invert is sampled per cycle for lk_data. For the scan engine it is latched with scan_start and held for the whole stream.
- Undefined: port absent, never inverted.

Test Plan:
- Reset then idle -> lk_data=0, row_valid=0, scan_busy=0; assert rst_n low mid-cycle -> outputs 0 without clk edge.
- lk_glyph=1, lk_row=8 -> next cycle lk_data=16'hFFFF; lk_row=6 -> 16'h0000; lk_glyph=2, lk_row=0 -> 16'h0180.
- scan_start with scan_glyph=3, row_ready=1 -> 16 consecutive beats, rows 4-6 and 9-11 = 16'hFFFF and others 0, row_last only at row_idx=15, scan_busy low the cycle after.
- scan glyph 1 with row_ready toggling 1/0 -> each row held stable while stalled; 16 beats total; no row skipped or duplicated.
- scan_start pulsed while busy and on the final-transfer cycle -> ignored; start one cycle after scan_busy falls -> accepted, row_idx=0.
- GLYPH_INVERT_EN defined, invert=1, scan glyph 0 -> 16 beats of 16'hFFFF; lk_glyph=3 (out of range when NUM_GLYPHS=3) -> lk_data=16'hFFFF.
